// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O unit: register addresses,
// status bit positions, reset values and small decode/status helpers.
package io_pkg;

   localparam logic [31:0] ADDR_HEX   = 32'hF000_0000;
   localparam logic [31:0] ADDR_LEDR  = 32'hF000_0004;
   localparam logic [31:0] ADDR_LEDG  = 32'hF000_0008;
   localparam logic [31:0] ADDR_KDATA = 32'hF000_0010;
   localparam logic [31:0] ADDR_KCTRL = 32'hF000_0110;
   localparam logic [31:0] ADDR_SDATA = 32'hF000_0014;
   localparam logic [31:0] ADDR_SCTRL = 32'hF000_0114;
   localparam logic [31:0] ADDR_TCNT  = 32'hF000_0020;
   localparam logic [31:0] ADDR_TLIM  = 32'hF000_0024;
   localparam logic [31:0] ADDR_TCTL  = 32'hF000_0120;

   localparam int READY   = 0;
   localparam int OVERRUN = 2;

   localparam logic [15:0] HEX_RST  = 16'h0000;
   localparam logic [9:0]  LEDR_RST = 10'h000;
   localparam logic [7:0]  LEDG_RST = 8'h00;
   localparam logic [31:0] TCNT_RST = 32'h0000_0000;
   localparam logic [31:0] TLIM_RST = 32'h0000_0000;

   typedef enum logic [3:0] {
      SEL_NONE,
      SEL_HEX,
      SEL_LEDR,
      SEL_LEDG,
      SEL_KDATA,
      SEL_KCTRL,
      SEL_SDATA,
      SEL_SCTRL,
      SEL_TCNT,
      SEL_TLIM,
      SEL_TCTL
   } reg_sel_t;

   typedef struct packed {
      logic ready;
      logic overrun;
   } status_t;

   localparam status_t STATUS_RST = '{ready: 1'b0, overrun: 1'b0};

   function automatic reg_sel_t decode(input logic [31:0] a);
      reg_sel_t s;
      case (a)
         ADDR_HEX:   s = SEL_HEX;
         ADDR_LEDR:  s = SEL_LEDR;
         ADDR_LEDG:  s = SEL_LEDG;
         ADDR_KDATA: s = SEL_KDATA;
         ADDR_KCTRL: s = SEL_KCTRL;
         ADDR_SDATA: s = SEL_SDATA;
         ADDR_SCTRL: s = SEL_SCTRL;
         ADDR_TCNT:  s = SEL_TCNT;
         ADDR_TLIM:  s = SEL_TLIM;
         ADDR_TCTL:  s = SEL_TCTL;
         default:    s = SEL_NONE;
      endcase
      return s;
   endfunction

   // Software clears are applied first so that a same-cycle set overrides them.
   function automatic status_t update_status(input status_t cur, input logic set,
                                             input logic wr, input logic [31:0] wdata);
      status_t nxt;
      nxt = cur;
      if (wr) begin
         if (!wdata[READY])   nxt.ready   = 1'b0;
         if (!wdata[OVERRUN]) nxt.overrun = 1'b0;
      end
      if (set) begin
         nxt.ready = 1'b1;
         if (cur.ready) nxt.overrun = 1'b1;
      end
      return nxt;
   endfunction

   function automatic logic [31:0] status_word(input status_t s);
      logic [31:0] w;
      w          = '0;
      w[READY]   = s.ready;
      w[OVERRUN] = s.overrun;
      return w;
   endfunction

endpackage

// File: rtl/io_debouncer.sv
// Two-flop synchroniser plus whole-vector debouncer; `changed` pulses in the
// cycle whose clock edge loads a new debounced value.
module io_debouncer #(
   parameter int WIDTH  = 4,
   parameter int CYCLES = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] raw,
   output logic [WIDTH-1:0] debounced,
   output logic             changed
);

   localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] sync2;
   logic [WIDTH-1:0] prev;
   logic [CW-1:0]    stable_cnt;
   logic             settled;
   logic             pending;

   assign settled = (sync2 == prev);
   assign pending = (sync2 != debounced);
   assign changed = settled && pending && (stable_cnt == CW'(CYCLES - 1));

   // The counter only advances while a stable difference is outstanding.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1      <= '0;
         sync2      <= '0;
         prev       <= '0;
         stable_cnt <= '0;
         debounced  <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         prev  <= sync2;
         if (!settled || !pending) begin
            stable_cnt <= '0;
         end else if (changed) begin
            stable_cnt <= '0;
            debounced  <= sync2;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mmio_io_unit.sv
// Memory-mapped I/O unit: address decode, LED/HEX output registers, debounced
// KEY/SW inputs with ready/overrun status, and a limit-wrapping interval timer.
module mmio_io_unit #(
   parameter int DBITS           = 32,
   parameter int TICK_CYCLES     = 10000,
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DBITS-1:0] addr,
   input  logic             wrtEn,
   input  logic [DBITS-1:0] dIn,
   output logic [DBITS-1:0] dOut,
   output logic             hit,
   input  logic [9:0]       sw,
   input  logic [3:0]       key,
   output logic [9:0]       ledr,
   output logic [7:0]       ledg,
   output logic [15:0]      hex
);

   import io_pkg::*;

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   logic [31:0]   addr32;
   logic [31:0]   din32;
   logic [31:0]   rdata;
   reg_sel_t      sel;
   logic          wr;

   logic [3:0]    key_deb;
   logic          key_changed;
   logic [9:0]    sw_deb;
   logic          sw_changed;

   status_t       k_stat;
   status_t       s_stat;
   status_t       t_stat;

   logic [PW-1:0] presc;
   logic [31:0]   tcnt;
   logic [31:0]   tlim;
   logic          tick;
   logic          wrap;

   assign addr32 = 32'(addr);
   assign din32  = 32'(dIn);
   assign sel    = decode(addr32);
   assign hit    = (sel != SEL_NONE);
   assign wr     = hit & wrtEn;

   // Keys are active-low on the board; inverting before the debouncer makes
   // the reset value of all zeros mean "nothing pressed".
   io_debouncer #(
      .WIDTH (4),
      .CYCLES(DEBOUNCE_CYCLES)
   ) u_key_deb (
      .clk      (clk),
      .reset    (reset),
      .raw      (~key),
      .debounced(key_deb),
      .changed  (key_changed)
   );

   io_debouncer #(
      .WIDTH (10),
      .CYCLES(DEBOUNCE_CYCLES)
   ) u_sw_deb (
      .clk      (clk),
      .reset    (reset),
      .raw      (sw),
      .debounced(sw_deb),
      .changed  (sw_changed)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         hex  <= HEX_RST;
         ledr <= LEDR_RST;
         ledg <= LEDG_RST;
      end else if (wr) begin
         if (sel == SEL_HEX)  hex  <= din32[15:0];
         if (sel == SEL_LEDR) ledr <= din32[9:0];
         if (sel == SEL_LEDG) ledg <= din32[7:0];
      end
   end

   assign tick = (presc == PW'(TICK_CYCLES - 1));
   // The limit compare uses the registered TLIM, so a same-cycle TLIM write
   // only affects later ticks.
   assign wrap = tick && (tlim != '0) && (tcnt == tlim - 32'd1);

   // A TCNT write overrides the tick update and restarts the prescaler phase.
   always_ff @(posedge clk) begin
      if (reset) begin
         presc <= '0;
         tcnt  <= TCNT_RST;
         tlim  <= TLIM_RST;
      end else begin
         if (wr && sel == SEL_TCNT) begin
            tcnt  <= din32;
            presc <= '0;
         end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) tcnt <= wrap ? 32'd0 : tcnt + 32'd1;
         end
         if (wr && sel == SEL_TLIM) tlim <= din32;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         k_stat <= STATUS_RST;
         s_stat <= STATUS_RST;
         t_stat <= STATUS_RST;
      end else begin
         k_stat <= update_status(k_stat, key_changed, wr && sel == SEL_KCTRL, din32);
         s_stat <= update_status(s_stat, sw_changed,  wr && sel == SEL_SCTRL, din32);
         t_stat <= update_status(t_stat, wrap,        wr && sel == SEL_TCTL,  din32);
      end
   end

   always_comb begin
      rdata = '0;
      case (sel)
         SEL_HEX:   rdata = 32'(hex);
         SEL_LEDR:  rdata = 32'(ledr);
         SEL_LEDG:  rdata = 32'(ledg);
         SEL_KDATA: rdata = 32'(key_deb);
         SEL_KCTRL: rdata = status_word(k_stat);
         SEL_SDATA: rdata = 32'(sw_deb);
         SEL_SCTRL: rdata = status_word(s_stat);
         SEL_TCNT:  rdata = tcnt;
         SEL_TLIM:  rdata = tlim;
         SEL_TCTL:  rdata = status_word(t_stat);
         default:   rdata = '0;
      endcase
   end

   assign dOut = DBITS'(rdata);

endmodule

// File: tb/tb_mmio_io_unit.sv
// Directed self-checking bench for mmio_io_unit with short debounce/tick
// periods so that every path is reached within a few hundred cycles.
module tb_mmio_io_unit;

   localparam logic [31:0] A_HEX   = 32'hF000_0000;
   localparam logic [31:0] A_LEDR  = 32'hF000_0004;
   localparam logic [31:0] A_LEDG  = 32'hF000_0008;
   localparam logic [31:0] A_NONE  = 32'hF000_000C;
   localparam logic [31:0] A_KDATA = 32'hF000_0010;
   localparam logic [31:0] A_KCTRL = 32'hF000_0110;
   localparam logic [31:0] A_SDATA = 32'hF000_0014;
   localparam logic [31:0] A_SCTRL = 32'hF000_0114;
   localparam logic [31:0] A_TCNT  = 32'hF000_0020;
   localparam logic [31:0] A_TLIM  = 32'hF000_0024;
   localparam logic [31:0] A_TCTL  = 32'hF000_0120;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic        wrtEn;
   logic [31:0] dIn;
   logic [31:0] dOut;
   logic        hit;
   logic [9:0]  sw;
   logic [3:0]  key;
   logic [9:0]  ledr;
   logic [7:0]  ledg;
   logic [15:0] hex;

   int errors = 0;
   int checks = 0;

   mmio_io_unit #(
      .DBITS          (32),
      .TICK_CYCLES    (3),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .addr (addr),
      .wrtEn(wrtEn),
      .dIn  (dIn),
      .dOut (dOut),
      .hit  (hit),
      .sw   (sw),
      .key  (key),
      .ledr (ledr),
      .ledg (ledg),
      .hex  (hex)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic write_reg(input logic [31:0] a, input logic [31:0] d);
      addr  = a;
      dIn   = d;
      wrtEn = 1'b1;
      step(1);
      wrtEn = 1'b0;
      dIn   = '0;
   endtask

   task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr  = a;
      wrtEn = 1'b0;
      #1;
      check(tag, dOut, exp);
   endtask

   initial begin
      int  lat;
      logic seen;

      reset = 1'b1;
      addr  = '0;
      wrtEn = 1'b0;
      dIn   = '0;
      sw    = '0;
      key   = 4'hF;
      step(2);
      reset = 1'b0;

      read_check("rst_tcnt", A_TCNT, 32'h0);
      check("rst_hit", {31'b0, hit}, 32'h1);
      read_check("rst_hex_rd", A_HEX, 32'h0);
      read_check("rst_kdata", A_KDATA, 32'h0);
      read_check("rst_kctrl", A_KCTRL, 32'h0);
      read_check("rst_sdata", A_SDATA, 32'h0);
      check("rst_hex_out", 32'(hex), 32'h0);
      check("rst_ledr_out", 32'(ledr), 32'h0);
      check("rst_ledg_out", 32'(ledg), 32'h0);

      // Output registers, unused bits and an unmapped address.
      write_reg(A_HEX, 32'hABCD_1234);
      check("hex_out", 32'(hex), 32'h1234);
      read_check("hex_rd", A_HEX, 32'h1234);
      write_reg(A_LEDR, 32'hFFFF_FFFF);
      check("ledr_out", 32'(ledr), 32'h3FF);
      read_check("ledr_rd", A_LEDR, 32'h3FF);
      write_reg(A_LEDG, 32'h0000_00A5);
      check("ledg_out", 32'(ledg), 32'hA5);
      read_check("ledg_rd", A_LEDG, 32'hA5);
      read_check("none_dout", A_NONE, 32'h0);
      check("none_hit", {31'b0, hit}, 32'h0);
      write_reg(A_NONE, 32'h0000_FFFF);
      check("none_wr_hex", 32'(hex), 32'h1234);

      // Key[1] pressed: accepted 2 + 4 cycles later, give or take one.
      key  = 4'b1101;
      addr = A_KDATA;
      lat  = 0;
      for (int i = 1; i <= 10; i++) begin
         step(1);
         if (dOut === 32'h2) begin
            lat = i;
            break;
         end
      end
      check("key_latency_ok", {31'b0, (lat >= 5 && lat <= 7)}, 32'h1);
      read_check("key_kdata", A_KDATA, 32'h2);
      read_check("key_kctrl", A_KCTRL, 32'h1);

      key = 4'b1100;
      step(2);
      key = 4'b1101;
      step(10);
      read_check("glitch_kdata", A_KDATA, 32'h2);
      read_check("glitch_kctrl", A_KCTRL, 32'h1);
      write_reg(A_KCTRL, 32'h0);
      read_check("kctrl_clr", A_KCTRL, 32'h0);

      // Two switch changes without a clear raise overrun.
      sw = 10'h001;
      step(8);
      read_check("sw1_sdata", A_SDATA, 32'h1);
      read_check("sw1_sctrl", A_SCTRL, 32'h1);
      sw = 10'h003;
      step(8);
      read_check("sw2_sdata", A_SDATA, 32'h3);
      read_check("sw2_sctrl", A_SCTRL, 32'h5);
      write_reg(A_SCTRL, 32'h1);
      read_check("sctrl_clr_ovr", A_SCTRL, 32'h1);
      write_reg(A_SCTRL, 32'h0);
      read_check("sctrl_clr_all", A_SCTRL, 32'h0);

      // Clear SCTRL on every cycle until the new value lands: the set must win.
      sw    = 10'h007;
      addr  = A_SCTRL;
      dIn   = 32'h0;
      wrtEn = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (dOut[0] === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      wrtEn = 1'b0;
      check("sctrl_set_wins", {31'b0, seen}, 32'h1);
      read_check("sw3_sdata", A_SDATA, 32'h7);
      read_check("sw3_sctrl", A_SCTRL, 32'h1);

      // Timer with TLIM = 2 and a tick every 3 cycles.
      read_check("tctl_idle", A_TCTL, 32'h0);
      write_reg(A_TLIM, 32'h2);
      write_reg(A_TCNT, 32'h0);
      read_check("tlim_rd", A_TLIM, 32'h2);
      read_check("tcnt_e0", A_TCNT, 32'h0);
      step(2);
      read_check("tcnt_e2", A_TCNT, 32'h0);
      step(1);
      read_check("tcnt_e3", A_TCNT, 32'h1);
      read_check("tctl_e3", A_TCTL, 32'h0);
      step(3);
      read_check("tcnt_e6", A_TCNT, 32'h0);
      read_check("tctl_e6", A_TCTL, 32'h1);
      step(6);
      read_check("tcnt_e12", A_TCNT, 32'h0);
      read_check("tctl_e12", A_TCTL, 32'h5);
      step(2);
      write_reg(A_TCNT, 32'h5);
      read_check("tcnt_wr_tick", A_TCNT, 32'h5);
      step(2);
      read_check("tcnt_hold", A_TCNT, 32'h5);
      step(1);
      read_check("tcnt_next", A_TCNT, 32'h6);

      // TCNT write in a wrap cycle: written value kept, ready still set.
      write_reg(A_TCTL, 32'h0);
      read_check("tctl_clr", A_TCTL, 32'h0);
      write_reg(A_TCNT, 32'h1);
      step(2);
      write_reg(A_TCNT, 32'h9);
      read_check("tcnt_wr_wrap", A_TCNT, 32'h9);
      read_check("tctl_wr_wrap", A_TCTL, 32'h1);

      // Reset while a key change is pending and the timer is running.
      key = 4'b0101;
      step(3);
      reset = 1'b1;
      step(2);
      reset = 1'b0;
      check("rst2_hex", 32'(hex), 32'h0);
      check("rst2_ledr", 32'(ledr), 32'h0);
      check("rst2_ledg", 32'(ledg), 32'h0);
      read_check("rst2_kdata", A_KDATA, 32'h0);
      read_check("rst2_kctrl", A_KCTRL, 32'h0);
      read_check("rst2_tcnt", A_TCNT, 32'h0);
      read_check("rst2_tlim", A_TLIM, 32'h0);
      read_check("rst2_tctl", A_TCTL, 32'h0);
      read_check("rst2_sdata", A_SDATA, 32'h0);
      step(1);
      read_check("rst2_sctrl", A_SCTRL, 32'h0);
      step(2);
      read_check("rst2_kdata_late", A_KDATA, 32'h0);
      step(10);
      read_check("rst2_kdata_new", A_KDATA, 32'hA);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
